// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
// Frame layout is {cmd[1:0], payload[DATA_W-1:0]}, MSB first on the wire.
package spi_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA,
      TX_WAIT,
      TX_SHIFT,
      DONE
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   function automatic int frame_w(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: a load presents the MSB on the same edge, the remaining
// bits follow one per clock, then MISO returns to 0 and done is flagged.
module spi_tx_shifter #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_miso,
   output logic              o_done
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] r_sh;
   logic [CW-1:0]     r_cnt;
   logic              r_active;
   logic              r_miso;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh     <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_miso   <= 1'b0;
      end else if (i_abort) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_miso   <= 1'b0;
      end else if (i_load) begin
         r_sh     <= i_data << 1;
         r_miso   <= i_data[DATA_W-1];
         r_cnt    <= CW'(DATA_W - 1);
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt != '0) begin
            r_miso <= r_sh[DATA_W-1];
            r_sh   <= r_sh << 1;
            r_cnt  <= r_cnt - CW'(1);
         end else begin
            r_miso   <= 1'b0;
            r_active <= 1'b0;
         end
      end
   end

   // done is high during the last driven bit so the FSM leaves TX_SHIFT
   // on the same edge that returns MISO to 0
   assign o_done = r_active && (r_cnt == '0);
   assign o_miso = r_miso;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: MOSI frame deserialiser with command checking, abort
// detection and a ready/valid MISO path. Optional parity: SPI_SLAVE_PARITY_EN.
module spi_slave_ctrl
   import spi_slave_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              frame_err,
   output logic              parity_err,
   output logic              busy
);

   localparam int FRAME_W = frame_w(DATA_W);
   localparam int CW      = $clog2(FRAME_W + 1);
`ifdef SPI_SLAVE_PARITY_EN
   localparam int SHIFT_W  = FRAME_W;
   localparam int LAST_CNT = FRAME_W;
`else
   localparam int SHIFT_W  = FRAME_W - 1;
   localparam int LAST_CNT = FRAME_W - 1;
`endif

   state_t               r_state, w_state_nxt;
   logic [SHIFT_W-1:0]   r_shift, w_shift_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic                 r_pend, w_pend_nxt;
   logic [FRAME_W-1:0]   r_rx_data;
   logic                 r_rx_valid, r_frame_err, r_parity_err, r_tx_ready;
   logic                 w_rx_valid, w_frame_err, w_parity_err, w_tx_ready_nxt;
   logic                 w_rx_load, w_tx_load, w_tx_abort, w_tx_done;
   logic [FRAME_W-1:0]   w_frame;
   logic [1:0]           w_cmd;
   logic                 w_cmd_ok;
   logic                 w_par_ok;

`ifdef SPI_SLAVE_PARITY_EN
   // Odd parity: the frame plus the trailing bit must hold an odd count of ones
   assign w_frame  = r_shift;
   assign w_par_ok = ^{r_shift, MOSI};
`else
   assign w_frame  = {r_shift, MOSI};
   assign w_par_ok = 1'b1;
`endif
   assign w_cmd = w_frame[FRAME_W-1:FRAME_W-2];

   always_comb begin
      w_cmd_ok = 1'b0;
      case (r_state)
         READ_ADD:  w_cmd_ok = (w_cmd == CMD_RD_ADDR);
         READ_DATA: w_cmd_ok = (w_cmd == CMD_RD_DATA);
         WRITE:     w_cmd_ok = (w_cmd == CMD_WR_ADDR) || (w_cmd == CMD_WR_DATA);
         default:   w_cmd_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_cnt_nxt      = r_cnt;
      w_pend_nxt     = r_pend;
      w_rx_valid     = 1'b0;
      w_frame_err    = 1'b0;
      w_parity_err   = 1'b0;
      w_rx_load      = 1'b0;
      w_tx_load      = 1'b0;
      w_tx_abort     = 1'b0;
      w_tx_ready_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (!SS_n) w_state_nxt = CHK_CMD;
         end
         CHK_CMD: begin
            if (SS_n) begin
               w_state_nxt = IDLE;
            end else begin
               w_shift_nxt = SHIFT_W'(MOSI);
               w_cnt_nxt   = CW'(1);
               if (!MOSI)      w_state_nxt = WRITE;
               else if (r_pend) w_state_nxt = READ_DATA;
               else             w_state_nxt = READ_ADD;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               w_state_nxt = IDLE;
               w_frame_err = 1'b1;
            end else if (r_cnt < CW'(LAST_CNT)) begin
               w_shift_nxt = {r_shift[SHIFT_W-2:0], MOSI};
               w_cnt_nxt   = r_cnt + CW'(1);
            end else if (!w_par_ok) begin
               w_parity_err = 1'b1;
               w_state_nxt  = DONE;
            end else if (w_cmd_ok) begin
               w_rx_valid = 1'b1;
               w_rx_load  = 1'b1;
               if (w_cmd == CMD_RD_ADDR) w_pend_nxt = 1'b1;
               if (w_cmd == CMD_RD_DATA) begin
                  w_pend_nxt  = 1'b0;
                  w_state_nxt = TX_WAIT;
               end else begin
                  w_state_nxt = DONE;
               end
            end else begin
               w_frame_err = 1'b1;
               w_state_nxt = DONE;
            end
         end
         TX_WAIT: begin
            if (SS_n) begin
               w_state_nxt = IDLE;
               w_frame_err = 1'b1;
            end else if (tx_valid && r_tx_ready) begin
               w_tx_load   = 1'b1;
               w_state_nxt = TX_SHIFT;
            end else begin
               w_tx_ready_nxt = 1'b1;
            end
         end
         TX_SHIFT: begin
            if (SS_n) begin
               w_state_nxt = IDLE;
               w_frame_err = 1'b1;
               w_tx_abort  = 1'b1;
            end else if (w_tx_done) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (SS_n) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_shift      <= '0;
         r_cnt        <= '0;
         r_pend       <= 1'b0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_tx_ready   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pend       <= w_pend_nxt;
         r_rx_valid   <= w_rx_valid;
         r_frame_err  <= w_frame_err;
         r_parity_err <= w_parity_err;
         r_tx_ready   <= w_tx_ready_nxt;
         if (w_rx_load) r_rx_data <= w_frame;
      end
   end

   spi_tx_shifter #(.DATA_W(DATA_W)) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_tx_load),
      .i_abort (w_tx_abort),
      .i_data  (tx_data),
      .o_miso  (MISO),
      .o_done  (w_tx_done)
   );

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign tx_ready   = r_tx_ready;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with an rx_data scoreboard.
// Uses DATA_W=16 and exercises parity when SPI_SLAVE_PARITY_EN is defined.
module tb_spi_slave_ctrl;

`ifdef SPI_SLAVE_PARITY_EN
   localparam int DW = 16;
`else
   localparam int DW = 8;
`endif
   localparam int FW = DW + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          SS_n;
   logic          MOSI;
   logic          MISO;
   logic [FW-1:0] rx_data;
   logic          rx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          frame_err;
   logic          parity_err;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int n_rxv = 0;
   int n_exp = 0;
   logic [FW-1:0] sb_q[$];

   spi_slave_ctrl #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_err(frame_err),
      .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rx_valid === 1'b1) begin
         n_rxv++;
         check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
   end

   // kind: 0 = accepted, 1 = frame_err, 2 = parity_err
   task automatic do_frame(input logic [1:0] cmd, input logic [DW-1:0] pl,
                           input bit bad_par, input int kind, input string tag);
      logic [FW-1:0] fr;
      fr = {cmd, pl};
      if (kind == 0) begin
         sb_q.push_back(fr);
         n_exp++;
      end
      @(negedge clk); SS_n = 1'b0;
      for (int i = FW - 1; i >= 0; i--) begin
         @(negedge clk); MOSI = fr[i];
      end
`ifdef SPI_SLAVE_PARITY_EN
      @(negedge clk); MOSI = (~^fr) ^ bad_par;
`endif
      @(negedge clk);
      check({tag, "_rxv"}, 32'(rx_valid), 32'(kind == 0));
      check({tag, "_ferr"}, 32'(frame_err), 32'(kind == 1));
      check({tag, "_perr"}, 32'(parity_err), 32'(kind == 2));
      check({tag, "_rdy_lo"}, 32'(tx_ready), 32'd0);
      @(negedge clk);
      check({tag, "_pulse"}, 32'({rx_valid, frame_err, parity_err}), 32'd0);
   endtask

   task automatic end_frame(input string tag);
      @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
      @(negedge clk);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int rx_before;
      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({MISO, rx_valid, tx_ready, frame_err, parity_err, busy}), 32'd0);
      check("rst_rxdata", 32'(rx_data), 32'd0);
      rst_n = 1'b1;

      // plain write frame, then DONE ignores further MOSI until SS_n rises
      do_frame(2'b00, DW'(8'hA5), 1'b0, 0, "wr");
      rx_before = n_rxv;
      repeat (4) begin
         @(negedge clk); MOSI = ~MOSI;
      end
      @(negedge clk);
      check("done_busy", 32'(busy), 32'd1);
      check("done_no_rx", 32'(n_rxv), 32'(rx_before));
      end_frame("wr");

      // read-address then read-data with a TX transfer
      do_frame(2'b10, DW'(8'h0F), 1'b0, 0, "ra");
      end_frame("ra");
      do_frame(2'b11, DW'(8'h5A), 1'b0, 0, "rd");
      check("tx_ready_up", 32'(tx_ready), 32'd1);
      d = DW'(8'hC3);
      tx_data = d; tx_valid = 1'b1;
      for (int i = DW - 1; i >= 0; i--) begin
         @(negedge clk); tx_valid = 1'b0;
         check("miso_bit", 32'(MISO), 32'(d[i]));
         check("tx_ready_lo", 32'(tx_ready), 32'd0);
      end
      @(negedge clk);
      check("miso_end", 32'(MISO), 32'd0);
      check("tx_done_busy", 32'(busy), 32'd1);
      end_frame("rd");

      // abort after 5 bits of a write frame
      @(negedge clk); SS_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); MOSI = i[0];
      end
      @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
      @(negedge clk);
      check("abort_ferr", 32'(frame_err), 32'd1);
      check("abort_rxv", 32'(rx_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort_pulse", 32'(frame_err), 32'd0);
      do_frame(2'b01, DW'(8'h3C), 1'b0, 0, "post_abort");
      end_frame("post_abort");

      // read-data command with no pending address: READ_ADD path mismatch
      do_frame(2'b11, DW'(8'h01), 1'b0, 1, "mis");
      end_frame("mis");
      do_frame(2'b11, DW'(8'h02), 1'b0, 1, "mis2");
      end_frame("mis2");

      // reset in the middle of a TX transfer
      do_frame(2'b10, DW'(8'h55), 1'b0, 0, "ra2");
      end_frame("ra2");
      do_frame(2'b11, DW'(8'h66), 1'b0, 0, "rd2");
      d = DW'(8'hFF);
      tx_data = d; tx_valid = 1'b1;
      for (int i = DW - 1; i >= DW - 3; i--) begin
         @(negedge clk); tx_valid = 1'b0;
         check("rst_tx_bit", 32'(MISO), 32'(d[i]));
      end
      rst_n = 1'b0;
      #1;
      check("rst_mid_miso", 32'(MISO), 32'd0);
      check("rst_mid_rdy", 32'(tx_ready), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      SS_n = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      do_frame(2'b11, DW'(8'h77), 1'b0, 1, "post_rst");
      end_frame("post_rst");

`ifdef SPI_SLAVE_PARITY_EN
      do_frame(2'b00, 16'h1234, 1'b1, 2, "par_bad");
      end_frame("par_bad");
      do_frame(2'b00, 16'h1234, 1'b0, 0, "par_ok");
      end_frame("par_ok");
`endif

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("rx_count", 32'(n_rxv), 32'(n_exp));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised SPI slave front end for the SPI-RAM wrapper. It deserialises MOSI command/address/data frames of configurable width onto a parallel `rx_data`/`rx_valid` interface toward the RAM. It serialises RAM read data onto MISO through a ready/valid handshake. Compared with the first-generation slave it adds explicit abort detection, command checking, a TX handshake and optional frame parity.

## Interface
- `DATA_W`, 8: payload bits per frame. Frame width `FRAME_W = DATA_W + 2` (2-bit command + payload).
- `clk`  in  1  system clock; SPI bits are sampled on its rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; 0 when not shifting.
- `rx_data`  out  FRAME_W  received frame `{cmd[1:0], payload}`.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` valid.
- `tx_data`  in  DATA_W  read data from RAM.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  slave waiting for read data.
- `frame_err`  out  1  one-cycle pulse: aborted or illegal frame.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied 0 without the parity macro.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Commands: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE→CHK_CMD when `SS_n`=0.
- In CHK_CMD, MOSI is sampled as frame bit FRAME_W-1 and stored. Next state:
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_pending`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_pending`=1 → READ_DATA.
- WRITE, READ_ADD and READ_DATA shift the remaining FRAME_W-1 bits into a shift register. The bit counter is `$clog2(FRAME_W+1)` wide.
- On the last bit, the slave checks the command:
  - READ_ADD requires 10.
  - READ_DATA requires 11.
  - WRITE accepts 00 or 01.
- Command match: `rx_valid` pulses and `rx_data` = the full frame.
  - 10 sets `rd_addr_pending`.
  - 11 clears `rd_addr_pending`.
  - Next state is DONE, or TX_WAIT for cmd 11.
- Command mismatch: no `rx_valid`, `frame_err` pulses, `rd_addr_pending` is unchanged, next state is DONE.
- TX_WAIT: `tx_ready`=1. `tx_valid` is ignored in every other state.
- TX_SHIFT: drives DATA_W bits, MSB first, then moves to DONE.
- DONE: MISO=0, further MOSI bits are ignored, exits to IDLE on `SS_n`=1.
- Abort (`SS_n`=1 in any state other than IDLE or DONE):
  - Next state IDLE, MISO=0, partial frame discarded.
  - `frame_err` pulses if at least one bit was captured or the state is TX_WAIT/TX_SHIFT.
  - `rd_addr_pending` is unchanged.
- Reset values: MISO=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=0, `frame_err`=0, `parity_err`=0, `busy`=0, `rd_addr_pending`=0, state IDLE.
- Reset mid-frame or mid-TX takes effect immediately and forces all of the above.

## Timing
- Edge k samples `SS_n`=0 (IDLE→CHK_CMD).
- Frame bits are sampled at edges k+1 through k+FRAME_W.
- `rx_data` and `rx_valid` are registered at edge k+FRAME_W. `rx_valid` is high for exactly one cycle and `rx_data` holds until the next frame start.
- `tx_ready` rises in the cycle after `rx_valid`.
- A handshake at edge t (`tx_valid`&`tx_ready`) captures `tx_data` and registers MISO=`tx_data[DATA_W-1]` at edge t.
- Bit i is on MISO after edge t+(DATA_W-1-i). MISO returns to 0 at edge t+DATA_W.
- `tx_ready` is low from the handshake edge onward.
- `rx_valid`, `frame_err` and `parity_err` are mutually exclusive in any cycle.

## Configuration
- `SPI_SLAVE_PARITY_EN` defined:
  - Each MOSI frame carries one extra trailing odd-parity bit over the FRAME_W bits, sampled at edge k+FRAME_W+1.
  - `rx_valid` (or `frame_err` on command mismatch) moves to that edge.
  - A parity mismatch gives `parity_err` for one cycle, no `rx_valid`, no `rd_addr_pending` update, next state DONE. Parity is checked before the command.
  - MISO data carries no parity.
- Undefined: no parity bit, and `parity_err` is constant 0.

## Structure
- Package `spi_slave_pkg`: state enum, command constants (`CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`), and a `frame_w(DATA_W)` function.
- Sub-module `spi_tx_shifter` (parameter DATA_W): load/shift/done for MISO. It is instantiated once and owns the MISO register.

## Test plan
- DATA_W=8, MOSI 00_1010_0101 → one `rx_valid` at edge k+10, `rx_data`=10'h0A5, no errors, DONE until `SS_n` rises.
- Frame 10_0000_1111, then frame 11_xxxx_xxxx → two `rx_valid` pulses, then `tx_ready`. With `tx_valid` and `tx_data`=8'hC3, MISO sequence is 1,1,0,0,0,0,1,1, then 0.
- `SS_n` raised after 5 bits of a write frame → no `rx_valid`, `frame_err` for 1 cycle, state IDLE. The next full frame is received correctly.
- No pending read-address, frame 11_0000_0001 → READ_ADD path, command mismatch: `frame_err`, no `rx_valid`, `rd_addr_pending` stays 0.
- `rst_n` pulsed low after the 3rd MISO bit → MISO, `tx_ready` and `busy` are 0 immediately. The next read-data frame takes the READ_ADD path.
- `SPI_SLAVE_PARITY_EN`, DATA_W=16: frame 00_0x1234 with a wrong parity bit → `parity_err` for 1 cycle, no `rx_valid`. With correct parity → `rx_valid`, `rx_data`=18'h01234.
